// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU with a busy
// down-counter, plus single-cycle MTHI/MTLO writes and cancel/reset abort.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count;
    logic [31:0]   a_q, b_q;
    logic          div_q, signed_q;
    logic          accept_md;

    // Only a multiply/divide needs its operands held; MTHI/MTLO write straight through.
    assign accept_md = !reset && !busy && start && !cancel && (op[2] == 1'b0);

    // NOTE: operand holding registers carry no reset; they are only read while busy,
    // and busy is always loaded together with them.
    always_ff @(posedge clk) begin
        if (accept_md) begin
            a_q      <= rs_val;
            b_q      <= rt_val;
            div_q    <= op[1];
            signed_q <= ~op[0];
        end
    end

    // Result datapath, evaluated from the held operands.
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic        q_neg, r_neg;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        a_ext   = {{32{signed_q & a_q[31]}}, a_q};
        b_ext   = {{32{signed_q & b_q[31]}}, b_q};
        product = a_ext * b_ext;

        // Sign-magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
        q_neg = signed_q & (a_q[31] ^ b_q[31]);
        r_neg = signed_q & a_q[31];
        a_mag = (signed_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag = (signed_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end

        if (div_q) begin
            res_lo = q_neg ? (~q_mag + 32'd1) : q_mag;
            res_hi = r_neg ? (~r_mag + 32'd1) : r_mag;
        end else begin
            res_lo = product[31:0];
            res_hi = product[63:32];
        end
    end

    // Priority: reset, then cancel, then completion / acceptance.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (busy) begin
            if (cancel) begin
                busy  <= 1'b0;
                count <= '0;
            end else if (count == CW'(1)) begin
                busy  <= 1'b0;
                count <= '0;
                if (!(div_q && b_q == 32'd0)) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                count <= count - CW'(1);
            end
        end else if (start && !cancel) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    busy  <= 1'b1;
                    count <= CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    busy  <= 1'b1;
                    count <= CW'(DIV_CYCLES);
                end
                OP_MTHI: hi <= rs_val;
                OP_MTLO: lo <= rs_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of HI/LO and busy.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi, m_plo;
    int          m_left = 0;
    logic        m_wr;

    task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        m_wr = 1'b1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; m_phi = p[63:32]; m_plo = p[31:0]; end
            3'd2: if (b == 0) m_wr = 1'b0;
                  else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
            default: if (b == 0) m_wr = 1'b0;
                  else begin m_plo = a / b; m_phi = a % b; end
        endcase
    endtask

    task automatic model_step();
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (cancel) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0 && m_wr) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (start && !cancel) begin
            if (op <= 3'd3) begin
                compute(op, rs_val, rt_val);
                m_left = (op <= 3'd1) ? MC : DC;
            end else if (op == 3'd4) m_hi = rs_val;
            else if (op == 3'd5) m_lo = rs_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy", 32'(busy), 32'(m_left > 0));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = s; op = o; rs_val = a; rt_val = b;
    endtask

    // Accept one op, scramble the inputs, and count busy cycles until it falls.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(1'b1, o, a, b);
        tick();
        drive(1'b0, 3'd7, $urandom, $urandom);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        logic [31:0] old_hi, old_lo;

        reset = 1'b1; cancel = 1'b0;
        drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0);
        tick(); tick();
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Multiplies.
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_cycles", n, MC);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("multu_cycles", n, MC);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // Divides, including divide-by-zero and the overflow case.
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
        check("div_cycles", n, DC);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, n);
        check("divu0_cycles", n, DC);
        check("divu0_hi", hi, 32'hFFFF_FFFF);
        check("divu0_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        // MTHI while idle, then ignored while busy.
        drive(1'b1, 3'd4, 32'h1234_5678, 32'h0);
        tick();
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'h0);
        drive(1'b1, 3'd0, 32'd2, 32'd3);
        tick();
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'h0);
        tick(); tick();
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        n = 0;
        while (busy && n < 50) begin n++; tick(); end
        check("mthi_busy_ign_hi", hi, 32'h0);
        check("mthi_busy_lo", lo, 32'd6);

        // No-op codes.
        drive(1'b1, 3'd6, 32'h5555_5555, 32'h1);
        tick();
        check("nop_busy", 32'(busy), 32'h0);
        check("nop_hi", hi, 32'h0);

        // Cancel in busy cycle 3 of MULT.
        drive(1'b1, 3'd4, 32'hA5A5_A5A5, 32'h0); tick();
        drive(1'b1, 3'd5, 32'h5A5A_5A5A, 32'h0); tick();
        drive(1'b1, 3'd0, 32'd100, 32'd100); tick();
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        tick(); tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'h0);
        repeat (6) tick();
        check("cancel_hi", hi, 32'hA5A5_A5A5);
        check("cancel_lo", lo, 32'h5A5A_5A5A);

        // Cancel coinciding with the completion edge.
        drive(1'b1, 3'd0, 32'd100, 32'd100); tick();
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        repeat (MC - 1) tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("cancel_done_lo", lo, 32'h5A5A_5A5A);
        check("cancel_done_busy", 32'(busy), 32'h0);

        // Cancel beats an idle MTHI.
        cancel = 1'b1; drive(1'b1, 3'd4, 32'h0BAD_0BAD, 32'h0); tick();
        cancel = 1'b0; drive(1'b0, 3'd7, 32'h0, 32'h0);
        check("cancel_idle_hi", hi, 32'hA5A5_A5A5);

        // Reset in cycle 4 of DIV.
        drive(1'b1, 3'd3, 32'd1000, 32'd7); tick();
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        repeat (3) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'h0);
        repeat (DC + 2) tick();
        check("rstmid_hi", hi, 32'h0);
        check("rstmid_lo", lo, 32'h0);

        // Back-to-back: start stays high from the first acceptance.
        drive(1'b1, 3'd0, 32'd4, 32'd5); tick();
        drive(1'b1, 3'd1, 32'd7, 32'd9);
        n = 0;
        while (busy && n < 50) begin n++; tick(); end
        check("b2b_first_lo", lo, 32'd20);
        check("b2b_gap_busy", 32'(busy), 32'h0);
        tick();
        check("b2b_accept_busy", 32'(busy), 32'h1);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        n = 0;
        while (busy && n < 50) begin n++; tick(); end
        check("b2b_cycles", n, MC);
        check("b2b_second_lo", lo, 32'd63);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            cancel = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rand_val(), rand_val());
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
